// File: rtl/snn_sched_pkg.sv
// Shared types and defaults for the spiking-network time-step scheduler.
package snn_sched_pkg;

   localparam int unsigned DEF_TIME_STEPS = 8;
   localparam int unsigned DEF_NUM_LAYERS = 3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_LAUNCH    = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_NEXT      = 3'd5
   } sched_state_t;

   // Counter width for n distinct values, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/timestep_scheduler_if.sv
// Frame input, layer launch/avail handshake and status bundle of the scheduler.
interface timestep_scheduler_if
   import snn_sched_pkg::*;
#(
   parameter int unsigned NUM_LAYERS = DEF_NUM_LAYERS,
   parameter int unsigned TIME_STEPS = DEF_TIME_STEPS,
   parameter int unsigned IN_SIZE    = 32
);
   localparam int unsigned STEP_W = clog2_min1(TIME_STEPS);

   logic                  start;
   logic                  in_valid;
   logic [IN_SIZE-1:0]    in_spk_train;
   logic                  in_ready;
   logic [IN_SIZE-1:0]    spk_frame;
   logic [NUM_LAYERS-1:0] layer_avail;
   logic [NUM_LAYERS-1:0] layer_start;
   logic [STEP_W-1:0]     cur_step;
   logic                  busy;
   logic                  done;
   logic                  err_timeout;

   modport master (
      output start, in_valid, in_spk_train, layer_avail,
      input  in_ready, spk_frame, layer_start, cur_step, busy, done, err_timeout
   );

   modport slave (
      input  start, in_valid, in_spk_train, layer_avail,
      output in_ready, spk_frame, layer_start, cur_step, busy, done, err_timeout
   );

endinterface

// File: rtl/timestep_scheduler.sv
// Sequences NUM_LAYERS event-control layers over TIME_STEPS steps per inference,
// one layer at a time, with a launch-acknowledge watchdog.
module timestep_scheduler
   import snn_sched_pkg::*;
#(
   parameter int unsigned NUM_LAYERS  = DEF_NUM_LAYERS,
   parameter int unsigned TIME_STEPS  = DEF_TIME_STEPS,
   parameter int unsigned IN_SIZE     = 32,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input logic                 clk,
   input logic                 rst,
   timestep_scheduler_if.slave bus
);

   localparam int unsigned LAYER_W = clog2_min1(NUM_LAYERS);
   localparam int unsigned STEP_W  = clog2_min1(TIME_STEPS);
   localparam int unsigned WDOG_W  = clog2_min1(ACK_TIMEOUT + 1);

   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
   localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(TIME_STEPS - 1);
   localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(ACK_TIMEOUT - 1);

   sched_state_t          state_q, state_d;
   logic [LAYER_W-1:0]    layer_q, layer_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic [WDOG_W-1:0]     wdog_q, wdog_d;
   logic [IN_SIZE-1:0]    frame_q, frame_d;
   logic [NUM_LAYERS-1:0] launch_q, launch_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  avail_c;

   assign avail_c = bus.layer_avail[layer_q];

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         layer_q  <= '0;
         step_q   <= '0;
         wdog_q   <= '0;
         frame_q  <= '0;
         launch_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         step_q   <= step_d;
         wdog_q   <= wdog_d;
         frame_q  <= frame_d;
         launch_q <= launch_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      step_d   = step_q;
      wdog_d   = wdog_q;
      frame_d  = frame_q;
      launch_d = '0;
      done_d   = 1'b0;
      err_d    = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_FETCH;
               layer_d = '0;
               step_d  = '0;
               err_d   = 1'b0;
            end
         end
         ST_FETCH: begin
            if (bus.in_valid) begin
               frame_d = bus.in_spk_train;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (avail_c) begin
               launch_d = NUM_LAYERS'(1) << layer_q;
               wdog_d   = '0;
               state_d  = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // The launch pulse is on the wire during the first cycle here.
            if (!avail_c) begin
               state_d = ST_WAIT_DONE;
            end else if (wdog_q == WDOG_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (avail_c) begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (layer_q != LAST_LAYER) begin
               layer_d = layer_q + LAYER_W'(1);
               state_d = ST_LAUNCH;
            end else if (step_q != LAST_STEP) begin
               layer_d = '0;
               step_d  = step_q + STEP_W'(1);
               state_d = ST_FETCH;
            end else begin
               layer_d = '0;
               step_d  = '0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d = (state_d == ST_FETCH);
      busy_d  = (state_d != ST_IDLE);
   end

   assign bus.in_ready    = ready_q;
   assign bus.spk_frame   = frame_q;
   assign bus.layer_start = launch_q;
   assign bus.cur_step    = step_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_timestep_scheduler.sv
// Directed bench for timestep_scheduler with behavioral event-control layers.
module tb_timestep_scheduler;

   localparam int unsigned NL = 3;
   localparam int unsigned TS = 2;
   localparam int unsigned IW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   timestep_scheduler_if #(.NUM_LAYERS(NL), .TIME_STEPS(TS), .IN_SIZE(IW)) bus ();

   timestep_scheduler #(
      .NUM_LAYERS(NL), .TIME_STEPS(TS), .IN_SIZE(IW), .ACK_TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int fails  = 0;

   // Behavioral layers: avail drops the edge after start, returns 5 cycles later.
   logic [NL-1:0] model_avail;
   logic [NL-1:0] avail_mask = '0;
   logic [NL-1:0] never_ack  = '0;
   int            lcnt [NL];

   always @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (rst) begin
            model_avail[i] <= 1'b1;
            lcnt[i]        <= 0;
         end else if (bus.layer_start[i] && !never_ack[i]) begin
            model_avail[i] <= 1'b0;
            lcnt[i]        <= 5;
         end else if (lcnt[i] > 0) begin
            if (lcnt[i] == 1) model_avail[i] <= 1'b1;
            lcnt[i] <= lcnt[i] - 1;
         end
      end
   end

   assign bus.layer_avail = model_avail & ~avail_mask;

   // Cycle counter and launch/done monitor.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pulse_q [$];
   int step_q  [$];
   int cyc_q   [$];
   int done_total = 0;
   int done_cyc   = 0;
   int multi_cnt  = 0;

   always @(negedge clk) begin
      if (!rst && bus.layer_start != '0) begin
         for (int i = 0; i < NL; i++)
            if (bus.layer_start[i]) pulse_q.push_back(i);
         step_q.push_back(int'(bus.cur_step));
         cyc_q.push_back(cyc);
         if ($countones(bus.layer_start) > 1) multi_cnt <= multi_cnt + 1;
      end
      if (!rst && bus.done) begin
         done_total <= done_total + 1;
         done_cyc   <= cyc;
      end
   end

   int exp_layer [6] = '{0, 1, 2, 0, 1, 2};
   int exp_step  [6] = '{0, 0, 0, 1, 1, 1};
   int exp_gap   [5] = '{9, 9, 10, 9, 9};

   task automatic pulse_start(output int acc_cyc);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_pulses(input int target, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         if (pulse_q.size() >= target) seen = 1'b1;
      end
   endtask

   task automatic wait_done(input int base, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         if (done_total > base) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_spk_train = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.busy, bus.done, bus.err_timeout} !== 4'b0000) begin
         fails++; $display("FAIL reset_flags: got %b want 0000",
                           {bus.in_ready, bus.busy, bus.done, bus.err_timeout});
      end
      checks++;
      if (bus.layer_start !== 3'b000 || bus.cur_step !== 1'b0) begin
         fails++; $display("FAIL reset_launch_step: start=%b step=%0d want 000/0",
                           bus.layer_start, bus.cur_step);
      end
      checks++;
      if (bus.spk_frame !== 32'h0) begin
         fails++; $display("FAIL reset_frame: got %h want 0", bus.spk_frame);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (pulse_q.size() != 0 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL reset_quiet: pulses=%0d busy=%b want 0/0", pulse_q.size(), bus.busy);
      end
   endtask

   task automatic test_full_run();
      int base, base_done, acc;
      bit seen;
      base = pulse_q.size(); base_done = done_total;
      bus.in_valid = 1'b1; bus.in_spk_train = 32'h1234_5678;
      pulse_start(acc);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
         fails++; $display("FAIL run_fetch: busy=%b in_ready=%b want 1/1", bus.busy, bus.in_ready);
      end
      wait_done(base_done, 200, seen);
      checks++;
      if (!seen) begin fails++; $display("FAIL run_done_timeout: done not seen, want 1"); end
      @(negedge clk);
      checks++;
      if (pulse_q.size() != base + 6) begin
         fails++; $display("FAIL run_pulse_count: got %0d want 6", pulse_q.size() - base);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (pulse_q[base+i] != exp_layer[i] || step_q[base+i] != exp_step[i]) begin
               fails++; $display("FAIL run_order[%0d]: layer=%0d step=%0d want %0d/%0d", i,
                                 pulse_q[base+i], step_q[base+i], exp_layer[i], exp_step[i]);
            end
         end
         checks++;
         if (cyc_q[base] - acc != 2) begin
            fails++; $display("FAIL run_first_latency: got %0d want 2", cyc_q[base] - acc);
         end
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (cyc_q[base+i+1] - cyc_q[base+i] != exp_gap[i]) begin
               fails++; $display("FAIL run_gap[%0d]: got %0d want %0d", i,
                                 cyc_q[base+i+1] - cyc_q[base+i], exp_gap[i]);
            end
         end
         checks++;
         if (done_cyc - cyc_q[base+5] != 8) begin
            fails++; $display("FAIL run_done_latency: got %0d want 8", done_cyc - cyc_q[base+5]);
         end
      end
      repeat (5) @(negedge clk);
      checks++;
      if (done_total != base_done + 1 || bus.busy !== 1'b0 || bus.cur_step !== 1'b0) begin
         fails++; $display("FAIL run_end: dones=%0d busy=%b step=%0d want 1/0/0",
                           done_total - base_done, bus.busy, bus.cur_step);
      end
      checks++;
      if (bus.spk_frame !== 32'h1234_5678 || bus.err_timeout !== 1'b0) begin
         fails++; $display("FAIL run_frame: frame=%h err=%b want 12345678/0", bus.spk_frame, bus.err_timeout);
      end
   endtask

   task automatic test_fetch_stall();
      int base, base_done, acc, bad_ready;
      bit seen;
      base = pulse_q.size(); base_done = done_total; bad_ready = 0;
      bus.in_valid = 1'b0; bus.in_spk_train = 32'hDEAD_BEEF;
      pulse_start(acc);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b1) bad_ready++;
      end
      checks++;
      if (bad_ready != 0 || pulse_q.size() != base) begin
         fails++; $display("FAIL stall_fetch: not_ready_cycles=%0d pulses=%0d want 0/0",
                           bad_ready, pulse_q.size() - base);
      end
      checks++;
      if (bus.spk_frame !== 32'h1234_5678) begin
         fails++; $display("FAIL stall_hold: frame=%h want 12345678", bus.spk_frame);
      end
      bus.in_valid = 1'b1; bus.in_spk_train = 32'hA5A5_A5A5;
      @(negedge clk);
      checks++;
      if (bus.spk_frame !== 32'hA5A5_A5A5 || bus.in_ready !== 1'b0) begin
         fails++; $display("FAIL stall_capture: frame=%h in_ready=%b want a5a5a5a5/0",
                           bus.spk_frame, bus.in_ready);
      end
      wait_done(base_done, 200, seen);
      checks++;
      if (!seen || pulse_q.size() != base + 6) begin
         fails++; $display("FAIL stall_complete: done=%b pulses=%0d want 1/6", seen, pulse_q.size() - base);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_timeout();
      int base, base_done, acc, n;
      bit seen;
      base = pulse_q.size(); base_done = done_total;
      never_ack = 3'b010;
      bus.in_valid = 1'b1; bus.in_spk_train = 32'h0F0F_0F0F;
      pulse_start(acc);
      wait_pulses(base + 2, 100, seen);
      checks++;
      if (!seen || pulse_q[base+1] != 1) begin
         fails++; $display("FAIL tmo_launch: seen=%b want layer 1 launch", seen);
      end
      n = 0;
      while (n < 40 && bus.err_timeout !== 1'b1) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n != 16) begin fails++; $display("FAIL tmo_delay: got %0d cycles want 16", n); end
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         fails++; $display("FAIL tmo_idle: busy=%b in_ready=%b want 0/0", bus.busy, bus.in_ready);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (bus.err_timeout !== 1'b1 || done_total != base_done || pulse_q.size() != base + 2) begin
         fails++; $display("FAIL tmo_sticky: err=%b dones=%0d pulses=%0d want 1/0/2",
                           bus.err_timeout, done_total - base_done, pulse_q.size() - base);
      end
      never_ack = '0;
      base = pulse_q.size();
      pulse_start(acc);
      @(negedge clk);
      checks++;
      if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b1) begin
         fails++; $display("FAIL tmo_clear: err=%b busy=%b want 0/1", bus.err_timeout, bus.busy);
      end
      wait_done(base_done, 200, seen);
      checks++;
      if (!seen || pulse_q.size() != base + 6) begin
         fails++; $display("FAIL tmo_recover: done=%b pulses=%0d want 1/6", seen, pulse_q.size() - base);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      int base, base_done, acc, dummy;
      bit seen;
      base = pulse_q.size(); base_done = done_total;
      bus.in_valid = 1'b1; bus.in_spk_train = 32'h5555_AAAA;
      pulse_start(acc);
      wait_pulses(base + 2, 100, seen);
      pulse_start(dummy);
      @(negedge clk);
      checks++;
      if (bus.cur_step !== 1'b0 || bus.busy !== 1'b1 || bus.err_timeout !== 1'b0) begin
         fails++; $display("FAIL busy_start_a: step=%0d busy=%b err=%b want 0/1/0",
                           bus.cur_step, bus.busy, bus.err_timeout);
      end
      wait_pulses(base + 4, 100, seen);
      pulse_start(dummy);
      @(negedge clk);
      checks++;
      if (bus.cur_step !== 1'b1 || bus.busy !== 1'b1) begin
         fails++; $display("FAIL busy_start_b: step=%0d busy=%b want 1/1", bus.cur_step, bus.busy);
      end
      wait_done(base_done, 200, seen);
      repeat (10) @(negedge clk);
      checks++;
      if (pulse_q.size() != base + 6 || done_total != base_done + 1 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL busy_totals: pulses=%0d dones=%0d busy=%b want 6/1/0",
                           pulse_q.size() - base, done_total - base_done, bus.busy);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (pulse_q[base+i] != exp_layer[i] || step_q[base+i] != exp_step[i] ||
                cyc_q[base+i+1] - cyc_q[base+i] != exp_gap[i]) begin
               fails++; $display("FAIL busy_order[%0d]: layer=%0d step=%0d gap=%0d want %0d/%0d/%0d", i,
                                 pulse_q[base+i], step_q[base+i], cyc_q[base+i+1] - cyc_q[base+i],
                                 exp_layer[i], exp_step[i], exp_gap[i]);
            end
         end
      end
   endtask

   task automatic test_launch_blocked();
      int base, base_done, acc;
      bit seen;
      base = pulse_q.size(); base_done = done_total;
      avail_mask = 3'b001;
      bus.in_valid = 1'b1; bus.in_spk_train = 32'h0000_FFFF;
      pulse_start(acc);
      repeat (8) @(negedge clk);
      checks++;
      if (pulse_q.size() != base || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         fails++; $display("FAIL blocked_hold: pulses=%0d busy=%b in_ready=%b want 0/1/0",
                           pulse_q.size() - base, bus.busy, bus.in_ready);
      end
      avail_mask = '0;
      @(negedge clk);
      checks++;
      if (bus.layer_start !== 3'b001) begin
         fails++; $display("FAIL blocked_release: layer_start=%b want 001", bus.layer_start);
      end
      wait_done(base_done, 200, seen);
      @(negedge clk);
      checks++;
      if (pulse_q.size() != base + 6 || done_total != base_done + 1) begin
         fails++; $display("FAIL blocked_totals: pulses=%0d dones=%0d want 6/1",
                           pulse_q.size() - base, done_total - base_done);
      end else begin
         checks++;
         if (pulse_q[base] != 0 || pulse_q[base+1] != 1 || pulse_q[base+3] != 0) begin
            fails++; $display("FAIL blocked_order: %0d,%0d,%0d want 0,1,0",
                              pulse_q[base], pulse_q[base+1], pulse_q[base+3]);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int base, base_done, acc;
      bit seen;
      base = pulse_q.size(); base_done = done_total;
      bus.in_valid = 1'b1; bus.in_spk_train = 32'hCAFE_F00D;
      pulse_start(acc);
      wait_pulses(base + 6, 200, seen);
      checks++;
      if (!seen || pulse_q[base+5] != 2 || step_q[base+5] != 1) begin
         fails++; $display("FAIL mid_reach: seen=%b want layer 2 step 1 launch", seen);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.busy, bus.done, bus.err_timeout} !== 4'b0000 ||
          bus.layer_start !== 3'b000 || bus.cur_step !== 1'b0 || bus.spk_frame !== 32'h0) begin
         fails++; $display("FAIL mid_reset: rdy=%b busy=%b done=%b err=%b start=%b step=%0d frame=%h want all 0",
                           bus.in_ready, bus.busy, bus.done, bus.err_timeout, bus.layer_start,
                           bus.cur_step, bus.spk_frame);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (done_total != base_done || pulse_q.size() != base + 6 || bus.busy !== 1'b0) begin
         fails++; $display("FAIL mid_quiet: dones=%0d pulses=%0d busy=%b want 0/6/0",
                           done_total - base_done, pulse_q.size() - base, bus.busy);
      end
      base = pulse_q.size();
      pulse_start(acc);
      wait_done(base_done, 200, seen);
      @(negedge clk);
      checks++;
      if (!seen || pulse_q.size() != base + 6 || done_total != base_done + 1) begin
         fails++; $display("FAIL mid_rerun: done=%b pulses=%0d want 1/6", seen, pulse_q.size() - base);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (pulse_q[base+i] != exp_layer[i] || step_q[base+i] != exp_step[i]) begin
               fails++; $display("FAIL mid_order[%0d]: layer=%0d step=%0d want %0d/%0d", i,
                                 pulse_q[base+i], step_q[base+i], exp_layer[i], exp_step[i]);
            end
         end
      end
   endtask

   task automatic test_onehot();
      checks++;
      if (multi_cnt != 0) begin
         fails++; $display("FAIL onehot: multi-bit launch cycles=%0d want 0", multi_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_fetch_stall();
      test_timeout();
      test_start_while_busy();
      test_launch_blocked();
      test_reset_mid();
      test_onehot();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/timestep_scheduler.md
TIMESTEP_SCHEDULER -- requirements
Module: timestep_scheduler

Interface
REQ-001 Parameter NUM_LAYERS, default 3: number of chained event-control layers sequenced.
REQ-002 Parameter TIME_STEPS, default 8: time steps per inference.
REQ-003 Parameter IN_SIZE, default 32: input spike-frame width.
REQ-004 Parameter ACK_TIMEOUT, default 16: maximum cycles to wait for a layer to drop layer_avail after launch.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin an inference; ignored unless IDLE.
REQ-008 in_valid  input  1  input frame for the current step is valid.
REQ-009 in_spk_train  input  IN_SIZE  input spike frame for the current step.
REQ-010 in_ready  output  1  scheduler accepts a frame this cycle.
REQ-011 spk_frame  output  IN_SIZE  registered captured frame, driven to layer 0 spike-train input.
REQ-012 layer_avail  input  NUM_LAYERS  per-layer idle flag from each event-control unit.
REQ-013 layer_start  output  NUM_LAYERS  per-layer one-cycle launch pulse, wired to that layer's pre_synp_avail.
REQ-014 cur_step  output  clog2(TIME_STEPS)  index of the step in progress.
REQ-015 busy  output  1  high from start acceptance until done.
REQ-016 done  output  1  one-cycle pulse when the final layer of the final step completes.
REQ-017 err_timeout  output  1  sticky; set on an ack timeout, cleared only by rst or an accepted start.

Function
REQ-018 FSM states: IDLE, FETCH, LAUNCH, WAIT_ACK, WAIT_DONE, NEXT.
REQ-019 IDLE: on start -> FETCH; clear cur_step and layer index to 0; set busy; clear err_timeout.
REQ-020 FETCH: in_ready=1; on in_valid capture in_spk_train into spk_frame (visible next cycle) -> LAUNCH.
REQ-021 in_ready is 0 in every state except FETCH; spk_frame holds between captures.
REQ-022 LAUNCH: if layer_avail[k]=1, assert layer_start[k] for exactly that cycle -> WAIT_ACK; else stay in LAUNCH.
REQ-023 At most one layer_start bit is high in any cycle.
REQ-024 WAIT_ACK: on layer_avail[k]=0 -> WAIT_DONE; a same-cycle edge to 0 suffices. After ACK_TIMEOUT cycles without ack: set err_timeout, drop busy -> IDLE.
REQ-025 WAIT_DONE: on layer_avail[k]=1 -> NEXT; no timeout applies.
REQ-026 NEXT, k<NUM_LAYERS-1: k=k+1 -> LAUNCH.
REQ-027 NEXT, k=NUM_LAYERS-1 and cur_step<TIME_STEPS-1: k=0, cur_step+1 -> FETCH.
REQ-028 NEXT, k=NUM_LAYERS-1 and cur_step=TIME_STEPS-1: pulse done, drop busy, cur_step=0 -> IDLE.
REQ-029 Minimum latency per layer is 4 cycles plus the layer's busy time; layers run strictly sequentially within a step.
REQ-030 start while not IDLE is ignored with no side effects.
REQ-031 Layer index counter width is clog2(NUM_LAYERS), minimum 1; no wrap beyond NUM_LAYERS-1.

Reset
REQ-032 rst has priority over all inputs, in any state including mid-WAIT_DONE.
REQ-033 Reset values: state=IDLE, cur_step=0, k=0, spk_frame=0, in_ready=0, layer_start=0, busy=0, done=0, err_timeout=0.
REQ-034 No layer_start pulse is emitted in the cycle rst deasserts.

Structure
REQ-035 Shared package snn_sched_pkg holds the FSM state enum and the default TIME_STEPS and NUM_LAYERS constants.
REQ-036 No sub-module is required; the ack watchdog is an inline counter of width clog2(ACK_TIMEOUT+1).

Verification
REQ-037 NUM_LAYERS=3, TIME_STEPS=2; behavioral layers drop avail 1 cycle after start and rise 5 cycles later; start -> 6 layer_start pulses in order 0,1,2,0,1,2 and exactly one done.
REQ-038 in_valid held low 10 cycles in FETCH -> no layer_start, in_ready stays 1; in_valid=1 with frame 0xA5A5A5A5 -> spk_frame=0xA5A5A5A5 the next cycle.
REQ-039 Layer 1 never drops avail, ACK_TIMEOUT=16 -> err_timeout=1 exactly 16 cycles after its launch, busy=0, no done pulse.
REQ-040 rst asserted during WAIT_DONE of layer 2, step 1 -> all outputs at reset values the next cycle; a new start runs cleanly from step 0.
REQ-041 start pulsed while busy -> cur_step and launch order unchanged; done pulses once.
REQ-042 layer_avail[0]=0 when LAUNCH is entered -> no pulse until avail returns to 1, then a single pulse.
